// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: encodes one (A, B, op) request into the 9-packet
// mtm_Alu serial frame and shifts it out on sin, one bit per clock.
// Each packet is start(0), type, 8 payload bits MSB first, stop(1).
// The frame carries B bytes, then A bytes, then the cmd packet {0, op, crc4}.
module mtm_alu_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        crc_err_i,
  output logic        sin,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP, GAP, DONE} state_t;

  // Reload value for the gap counter; the GAP state lasts GAP_LAST+1 cycles.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  pkt_q, pkt_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  gap_q, gap_d;
  logic        sin_q, sin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;

  logic        accept;
  logic [3:0]  crc;
  logic [7:0]  byte_cur;
  logic [2:0]  bit_nx;

  // CRC4, polynomial x^4+x+1, init 0, MSB first over {B, A, 1, op}.
  function automatic logic [3:0] crc4(input logic [67:0] s);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ s[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign accept    = req_valid & ready_q;
  assign crc       = crc4({b_q, a_q, 1'b1, op_q}) ^ {4{err_q}};
  assign bit_nx    = bit_q - 3'd1;
  assign sin       = sin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

  // Payload byte of the packet currently on the line.
  always_comb begin
    byte_cur = 8'hFF;
    case (pkt_q)
      4'd0:    byte_cur = b_q[31:24];
      4'd1:    byte_cur = b_q[23:16];
      4'd2:    byte_cur = b_q[15:8];
      4'd3:    byte_cur = b_q[7:0];
      4'd4:    byte_cur = a_q[31:24];
      4'd5:    byte_cur = a_q[23:16];
      4'd6:    byte_cur = a_q[15:8];
      4'd7:    byte_cur = a_q[7:0];
      4'd8:    byte_cur = {1'b0, op_q, crc};
      default: byte_cur = 8'hFF;
    endcase
  end

  // Next-state logic; sin_d is the bit the line carries in the next state.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sin_d   = sin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        sin_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          state_d = START;
          sin_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          pkt_d   = '0;
          bit_d   = '0;
          gap_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_i;
          err_d   = crc_err_i;
        end
      end
      START: begin
        state_d = TYPE;
        sin_d   = (pkt_q == 4'd8);
      end
      TYPE: begin
        state_d = DATA;
        bit_d   = 3'd7;
        sin_d   = byte_cur[7];
      end
      DATA: begin
        if (bit_q != 3'd0) begin
          bit_d = bit_nx;
          sin_d = byte_cur[bit_nx];
        end else begin
          state_d = STOP;
          sin_d   = 1'b1;
        end
      end
      STOP: begin
        pkt_d = (pkt_q >= 4'd9) ? 4'd9 : pkt_q + 4'd1;
        if (pkt_q < 4'd8) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            sin_d   = 1'b1;
            gap_d   = GAP_LAST;
          end else begin
            state_d = START;
            sin_d   = 1'b0;
          end
        end else begin
          state_d = DONE;
          sin_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        sin_d = 1'b1;
        if (gap_q == 4'd0) begin
          state_d = START;
          sin_d   = 1'b0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        sin_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        pkt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sin_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control state and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Request operands; only loaded on an accepted handshake.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    op_q  <= op_d;
    err_q <= err_d;
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: two instances (no gap, 3-cycle gap) share
// the request inputs. Expected line bits are queued when a request is
// issued and popped as the selected DUT shifts its frame out.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        err;
  logic        r0, s0, bz0, d0;
  logic        r1, s1, bz1, d1;
  logic        sel;
  logic        cs, cr, cb, cd;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  mtm_alu_serializer #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0),
    .a_i(a), .b_i(b), .op_i(op), .crc_err_i(err),
    .sin(s0), .busy(bz0), .done(d0)
  );

  mtm_alu_serializer #(.GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1),
    .a_i(a), .b_i(b), .op_i(op), .crc_err_i(err),
    .sin(s1), .busy(bz1), .done(d1)
  );

  always #5 clk = ~clk;

  assign cs = sel ? s1  : s0;
  assign cr = sel ? r1  : r0;
  assign cb = sel ? bz1 : bz0;
  assign cd = sel ? d1  : d0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [31:0] ra, input logic [31:0] rb,
                                         input logic [2:0] rop);
    logic [71:0] m;
    m = {rb, ra, 1'b1, rop, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic push_pkt(input bit typ, input logic [7:0] d);
    exp_q.push_back(1'b0);
    exp_q.push_back(typ);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic push_frame(input int gap);
    logic [63:0] ba;
    logic [3:0]  c;
    ba = {b, a};
    c  = ref_crc(a, b, op) ^ {4{err}};
    for (int p = 0; p < 8; p++) begin
      push_pkt(1'b0, ba[63 - 8*p -: 8]);
      for (int g = 0; g < gap; g++) exp_q.push_back(1'b1);
    end
    push_pkt(1'b1, {1'b0, op, c});
  endtask

  // Wait for ready and complete the handshake; returns in cycle k+1.
  task automatic handshake(input logic which, input string tag);
    int w;
    sel = which;
    @(negedge clk);
    if (which) v1 = 1'b1; else v0 = 1'b1;
    w = 0;
    while (cr !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "/ready_wait"}, cr, 1'b1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic run_frame(input logic which, input int gap, input string tag);
    int n;
    bit e;
    push_frame(gap);
    n = exp_q.size();
    handshake(which, tag);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s/sin%0d", tag, i), cs, e);
      chk($sformatf("%s/busy%0d", tag, i), cb, 1'b1);
      chk($sformatf("%s/done_early%0d", tag, i), cd, 1'b0);
      @(negedge clk);
    end
    chk({tag, "/done"}, cd, 1'b1);
    chk({tag, "/ready_at_done"}, cr, 1'b0);
    chk({tag, "/busy_at_done"}, cb, 1'b1);
    chk({tag, "/sin_at_done"}, cs, 1'b1);
    @(negedge clk);
    chk({tag, "/done_clear"}, cd, 1'b0);
    chk({tag, "/ready_after"}, cr, 1'b1);
    chk({tag, "/busy_after"}, cb, 1'b0);
  endtask

  initial begin
    bit e;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    a = '0; b = '0; op = '0; err = 1'b0;
    sel = 1'b0;
    #1;
    chk("rst/sin", s0, 1'b1);
    chk("rst/ready", r0, 1'b1);
    chk("rst/busy", bz0, 1'b0);
    chk("rst/done", d0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line with no requests.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle/line%0d", i), {s0, r0, bz0, d0, s1, r1, bz1, d1}, 8'b1100_1100);
    end

    // All-zero operation, then the same with CRC inversion.
    run_frame(1'b0, 0, "zero");
    err = 1'b1;
    run_frame(1'b0, 0, "zero_crcerr");
    err = 1'b0;

    // Distinct bytes to confirm packet order.
    a = 32'h01020304; b = 32'hAABBCCDD; op = 3'b100;
    run_frame(1'b0, 0, "order");

    // Random operations, including undefined op codes.
    for (int t = 0; t < 2; t++) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); err = 1'($urandom_range(0, 1));
      run_frame(1'b0, 0, $sformatf("rand%0d", t));
    end
    err = 1'b0;

    // Gapped frame: 123 bits with 3 idle cycles between packets.
    a = 32'h5A5A0F0F; b = 32'h12345678; op = 3'b011;
    run_frame(1'b1, 3, "gap3");

    // Reset during the 5th data packet (A[31:24]) abandons the frame.
    a = 32'hDEADBEEF; b = 32'hCAFEF00D; op = 3'b001;
    push_frame(0);
    handshake(1'b0, "rstmid");
    for (int i = 0; i < 44; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("rstmid/sin%0d", i), cs, e);
      @(negedge clk);
    end
    chk("rstmid/start_bit", cs, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid/sin_async", s0, 1'b1);
    chk("rstmid/busy_async", bz0, 1'b0);
    chk("rstmid/ready_async", r0, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid/hold%0d", i), {s0, r0, bz0, d0}, 4'b1100);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid/no_done%0d", i), {s0, r0, bz0, d0}, 4'b1100);
    end
    a = 32'h80000001; b = 32'h7FFFFFFE; op = 3'b110;
    run_frame(1'b0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
